if_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register, directly upstream of the main control decoder.
- Holds the PC and drives the instruction-memory address.
- Captures the returned instruction word into IF/ID and presents opcode bits [31:26] to the decoder.
- Handles stall, pipeline-flush redirect (branch/jump/jal target from downstream), and a not-ready instruction memory.

---
 rtl/if_stage.sv | 129 ++++++++++++
 tb/tb_if_stage.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// ============================================================================
//  Module   : if_stage
//  Purpose  : Instruction-fetch stage with PC register and IF/ID pipeline
//             register. Optional performance counters via IF_PERF_CNT_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module if_stage #(
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [31:0]       imem_data_i,
    input  logic              imem_ready_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [31:0]       if_id_instr_o,
    output logic [ADDR_W-1:0] if_id_pc4_o,
    output logic              if_id_valid_o,
    output logic [5:0]        instr_op_o,
    output logic [31:0]       perf_fetch_o,
    output logic [31:0]       perf_flush_o
);

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [31:0]         instr_q, instr_d;
    logic [ADDR_W-1:0]   pc4_q, pc4_d;
    logic                valid_q, valid_d;

    logic [ADDR_W-1:0]   w_pc_plus4;
    logic [ADDR_W-1:0]   w_redirect_pc;

    assign w_pc_plus4    = pc_q + ADDR_W'(4);
    // Targets are forced word-aligned.
    assign w_redirect_pc = redirect_pc_i & ~ADDR_W'(3);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
                instr_d = '0;
                valid_d = 1'b0;
            end
            default: begin
                if (redirect_i) begin
                    pc_d    = w_redirect_pc;
                    instr_d = '0;
                    valid_d = 1'b0;
                end else if (stall_i) begin
                    pc_d    = pc_q;
                end else if (!imem_ready_i) begin
                    instr_d = '0;
                    valid_d = 1'b0;
                end else begin
                    instr_d = imem_data_i;
                    pc4_d   = w_pc_plus4;
                    valid_d = 1'b1;
                    pc_d    = w_pc_plus4;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign imem_addr_o   = pc_q;
    assign pc_o          = pc_q;
    assign if_id_instr_o = instr_q;
    assign if_id_pc4_o   = pc4_q;
    assign if_id_valid_o = valid_q;
    assign instr_op_o    = instr_q[31:26];

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, flush_cnt_q;
    logic        w_fetch_evt, w_flush_evt;

    assign w_flush_evt = (state_q == ST_RUN) && redirect_i;
    assign w_fetch_evt = (state_q == ST_RUN) && !redirect_i && !stall_i && imem_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (w_fetch_evt) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (w_flush_evt) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign perf_fetch_o = fetch_cnt_q;
    assign perf_flush_o = flush_cnt_q;
`else
    assign perf_fetch_o = '0;
    assign perf_flush_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
//  Module   : tb_if_stage
//  Purpose  : Directed self-checking bench for if_stage.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_if_stage;

`ifdef IF_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        imem_ready = 1'b1;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [5:0]  op;
    logic [31:0] perf_fetch;
    logic [31:0] perf_flush;

    int checks = 0;
    int errors = 0;

    if_stage #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_addr_o   (imem_addr),
        .imem_data_i   (imem_data),
        .imem_ready_i  (imem_ready),
        .pc_o          (pc),
        .if_id_instr_o (instr),
        .if_id_pc4_o   (pc4),
        .if_id_valid_o (valid),
        .instr_op_o    (op),
        .perf_fetch_o  (perf_fetch),
        .perf_flush_o  (perf_flush)
    );

    always #5 clk = ~clk;

    // Instruction memory: two fixed words, everything else tagged with its address.
    always_comb begin
        case (imem_addr)
            32'h0000_0000: imem_data = 32'h8C01_0004;
            32'h0000_0004: imem_data = 32'h2002_0005;
            default:       imem_data = {16'hC0DE, imem_addr[15:0]};
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; imem_ready = 1'b1;
        step(); step();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want %h", pc, 32'h0); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h want 0", instr); end
        checks++; if (pc4 !== 32'h0) begin errors++; $display("FAIL rst_pc4 got %h want 0", pc4); end
        checks++; if (perf_fetch !== 32'h0) begin errors++; $display("FAIL rst_perf_fetch got %0d want 0", perf_fetch); end
        rst = 1'b1;
        step();
        checks++; if (valid !== 1'b0 || pc !== 32'h0) begin errors++; $display("FAIL boot got valid %b pc %h want 0 0", valid, pc); end
        step();
        checks++; if (instr !== 32'h8C01_0004) begin errors++; $display("FAIL fetch0_instr got %h want 8c010004", instr); end
        checks++; if (op !== 6'b100011) begin errors++; $display("FAIL fetch0_op got %b want 100011", op); end
        checks++; if (pc4 !== 32'h4 || pc !== 32'h4 || valid !== 1'b1) begin errors++; $display("FAIL fetch0_pc got pc4 %h pc %h v %b want 4 4 1", pc4, pc, valid); end
        step();
        checks++; if (instr !== 32'h2002_0005 || pc !== 32'h8) begin errors++; $display("FAIL fetch1 got instr %h pc %h want 20020005 8", instr, pc); end
    endtask

    task automatic test_stall();
        redirect = 1'b1; redirect_pc = 32'h10;
        step();
        redirect = 1'b0;
        step();
        checks++; if (pc !== 32'h14 || instr !== 32'hC0DE_0010 || pc4 !== 32'h14) begin errors++; $display("FAIL pre_stall got pc %h instr %h pc4 %h want 14 c0de0010 14", pc, instr, pc4); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (pc !== 32'h14 || instr !== 32'hC0DE_0010 || pc4 !== 32'h14 || valid !== 1'b1) begin errors++; $display("FAIL stall_hold%0d got pc %h instr %h pc4 %h v %b", i, pc, instr, pc4, valid); end
        end
        stall = 1'b0;
        step();
        checks++; if (instr !== 32'hC0DE_0014 || pc !== 32'h18 || pc4 !== 32'h18) begin errors++; $display("FAIL stall_resume got instr %h pc %h pc4 %h want c0de0014 18 18", instr, pc, pc4); end
    endtask

    task automatic test_redirect_over_stall();
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h43;
        step();
        checks++; if (pc !== 32'h40 || valid !== 1'b0 || instr !== 32'h0) begin errors++; $display("FAIL redir got pc %h v %b instr %h want 40 0 0", pc, valid, instr); end
        stall = 1'b0; redirect = 1'b0;
        step();
        checks++; if (instr !== 32'hC0DE_0040 || pc4 !== 32'h44 || valid !== 1'b1) begin errors++; $display("FAIL redir_target got instr %h pc4 %h v %b want c0de0040 44 1", instr, pc4, valid); end
    endtask

    task automatic test_imem_not_ready();
        redirect = 1'b1; redirect_pc = 32'h20;
        step();
        redirect = 1'b0; imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (pc !== 32'h20 || valid !== 1'b0) begin errors++; $display("FAIL notready%0d got pc %h v %b want 20 0", i, pc, valid); end
        end
        imem_ready = 1'b1;
        step();
        checks++; if (instr !== 32'hC0DE_0020 || pc !== 32'h24 || valid !== 1'b1) begin errors++; $display("FAIL ready_load got instr %h pc %h v %b want c0de0020 24 1", instr, pc, valid); end
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        step();
        checks++; if (pc4 !== 32'h0 || pc !== 32'h0 || instr !== 32'hC0DE_FFFC) begin errors++; $display("FAIL wrap got pc4 %h pc %h instr %h want 0 0 c0defffc", pc4, pc, instr); end
    endtask

    task automatic test_midstream_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        for (int i = 0; i < 5; i++) step();
        checks++; if (pc !== 32'h14 || perf_fetch !== (PERF ? 32'd5 : 32'd0)) begin errors++; $display("FAIL five_fetch got pc %h perf %0d want 14 %0d", pc, perf_fetch, PERF ? 5 : 0); end
        checks++; if (perf_flush !== 32'd0) begin errors++; $display("FAIL flush_pre got %0d want 0", perf_flush); end
        redirect = 1'b1; redirect_pc = 32'h80;
        step();
        redirect = 1'b0;
        checks++; if (perf_flush !== (PERF ? 32'd1 : 32'd0) || perf_fetch !== (PERF ? 32'd5 : 32'd0)) begin errors++; $display("FAIL flush_cnt got flush %0d fetch %0d", perf_flush, perf_fetch); end
        step();
        rst = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
        step();
        checks++; if (pc !== 32'h0 || valid !== 1'b0 || perf_fetch !== 32'd0 || perf_flush !== 32'd0) begin errors++; $display("FAIL mid_reset got pc %h v %b pf %0d pfl %0d want 0 0 0 0", pc, valid, perf_fetch, perf_flush); end
        rst = 1'b1; redirect = 1'b0;
        step();
        checks++; if (pc !== 32'h0 || valid !== 1'b0) begin errors++; $display("FAIL mid_boot got pc %h v %b want 0 0", pc, valid); end
        step();
        checks++; if (pc !== 32'h4 || instr !== 32'h8C01_0004) begin errors++; $display("FAIL post_reset got pc %h instr %h want 4 8c010004", pc, instr); end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect_over_stall();
        test_imem_not_ready();
        test_wrap();
        test_midstream_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
